// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift array, valid/ready on both sides.
// Build option: define CONV_WIN_REPLICATE_EN to clamp out-of-image taps to the nearest edge pixel instead of zero.
module conv_window_gen #(
  parameter int IMG_W = 160,
  parameter int IMG_H = 120,
  parameter int DW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] pix_in,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic [DW-1:0] win_00,
  output logic [DW-1:0] win_01,
  output logic [DW-1:0] win_02,
  output logic [DW-1:0] win_10,
  output logic [DW-1:0] win_11,
  output logic [DW-1:0] win_12,
  output logic [DW-1:0] win_20,
  output logic [DW-1:0] win_21,
  output logic [DW-1:0] win_22,
  output logic          win_valid,
  input  logic          win_ready,
  output logic          busy,
  output logic          frame_done
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_RUN,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [CW-1:0]   ccol_q, ccol_d;
  logic [RW-1:0]   crow_q, crow_d;
  logic            emit_done_q, emit_done_d;
  logic            win_valid_q, win_valid_d;
  logic            out_free;
  logic            fire;
  logic            emit;
  logic [DW-1:0]   pix_s;

  logic [DW-1:0]   lb0_q [IMG_W];
  logic [DW-1:0]   lb1_q [IMG_W];
  logic [DW-1:0]   s_q   [3][3];
  logic [DW-1:0]   s_d   [3][3];
  logic [DW-1:0]   win_q [3][3];
  logic [DW-1:0]   win_d [3][3];

  assign out_free = !win_valid_q || win_ready;

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    ccol_d      = ccol_q;
    crow_d      = crow_q;
    emit_done_d = emit_done_q;
    win_valid_d = win_valid_q;
    fire        = 1'b0;
    emit        = 1'b0;
    pix_s       = '0;

    if (win_valid_q && win_ready) win_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_FILL;
          col_d       = '0;
          row_d       = '0;
          ccol_d      = '0;
          crow_d      = '0;
          emit_done_d = 1'b0;
        end
      end
      S_FILL: begin
        fire  = pix_valid && out_free;
        pix_s = pix_in;
        if (fire && row_q == RW'(1) && col_q == '0) state_d = S_RUN;
      end
      S_RUN: begin
        fire  = pix_valid && out_free;
        pix_s = pix_in;
        emit  = fire;
        if (fire && row_q == ROW_LAST && col_q == COL_LAST) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        // Flush steps inject zeros; the border logic masks or clamps them away.
        fire = out_free && !emit_done_q;
        emit = fire;
        if (emit_done_q && win_valid_q && win_ready) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (fire) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end

    if (emit) begin
      win_valid_d = 1'b1;
      if (crow_q == ROW_LAST && ccol_q == COL_LAST) emit_done_d = 1'b1;
      if (ccol_q == COL_LAST) begin
        ccol_d = '0;
        crow_d = (crow_q == ROW_LAST) ? '0 : crow_q + RW'(1);
      end else begin
        ccol_d = ccol_q + CW'(1);
      end
    end
  end

  // Shift array after this step: oldest column drops out, the line-buffer column enters on the right.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      s_d[r][0] = s_q[r][1];
      s_d[r][1] = s_q[r][2];
    end
    s_d[0][2] = lb1_q[col_q];
    s_d[1][2] = lb0_q[col_q];
    s_d[2][2] = pix_s;
  end

  // Border handling keys off the centre counters, so the column that wrapped in from the next row is never used.
  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        logic top, bot, left, right;
        top   = (r == 0) && (crow_q == '0);
        bot   = (r == 2) && (crow_q == ROW_LAST);
        left  = (c == 0) && (ccol_q == '0);
        right = (c == 2) && (ccol_q == COL_LAST);
`ifdef CONV_WIN_REPLICATE_EN
        win_d[r][c] = s_d[(top || bot) ? 1 : r][(left || right) ? 1 : c];
`else
        win_d[r][c] = (top || bot || left || right) ? '0 : s_d[r][c];
`endif
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      ccol_q      <= '0;
      crow_q      <= '0;
      emit_done_q <= 1'b0;
      win_valid_q <= 1'b0;
      // NOTE: the line buffers are cleared on reset, which keeps them in flops rather than a RAM macro.
      for (int i = 0; i < IMG_W; i++) begin
        lb0_q[i] <= '0;
        lb1_q[i] <= '0;
      end
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          s_q[r][c]   <= '0;
          win_q[r][c] <= '0;
        end
      end
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ccol_q      <= ccol_d;
      crow_q      <= crow_d;
      emit_done_q <= emit_done_d;
      win_valid_q <= win_valid_d;
      if (fire) begin
        s_q          <= s_d;
        lb1_q[col_q] <= lb0_q[col_q];
        lb0_q[col_q] <= pix_s;
      end
      if (emit) win_q <= win_d;
    end
  end

  assign pix_ready  = (state_q == S_FILL || state_q == S_RUN) && out_free;
  assign busy       = (state_q == S_FILL || state_q == S_RUN || state_q == S_FLUSH);
  assign frame_done = (state_q == S_DONE);
  assign win_valid  = win_valid_q;

  assign win_00 = win_q[0][0];
  assign win_01 = win_q[0][1];
  assign win_02 = win_q[0][2];
  assign win_10 = win_q[1][0];
  assign win_11 = win_q[1][1];
  assign win_12 = win_q[1][2];
  assign win_20 = win_q[2][0];
  assign win_21 = win_q[2][1];
  assign win_22 = win_q[2][2];

endmodule
